// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory responder:
//   - access size codes (req_size encoding)
//   - MemRW read/write encoding (1 = read, 0 = write)
//   - FSM state enum used by dmem_responder
// No ports; imported by dmem_lane_ctrl and dmem_responder.
// ---------------------------------------------------------------------------
package dmem_pkg;

   localparam logic [1:0] SIZE_BYTE    = 2'b00;
   localparam logic [1:0] SIZE_HWORD   = 2'b01;
   localparam logic [1:0] SIZE_WORD    = 2'b10;
   localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

   localparam logic MemRW_Read  = 1'b1;
   localparam logic MemRW_Write = 1'b0;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      RESP = 2'b10
   } state_t;

endpackage

// File: rtl/dmem_lane_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_lane_ctrl
// Combinational byte-lane steering for a little-endian 32-bit word array.
// Ports:
//   size        in  2   access size code (byte / halfword / word / illegal)
//   lane        in  2   byte lane within the word (already force-aligned)
//   is_unsigned in  1   1 = zero-extend loads, 0 = sign-extend
//   wdata       in  32  right-aligned store data
//   rword       in  32  full array word at the addressed index
//   wstrb       out 4   per-byte write strobes
//   wword       out 32  store data replicated onto the addressed lanes
//   rdata       out 32  extracted and extended load data
// An illegal size yields no strobes and zero load data.
// ---------------------------------------------------------------------------
module dmem_lane_ctrl
   import dmem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  lane,
   input  logic        is_unsigned,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  wstrb,
   output logic [31:0] wword,
   output logic [31:0] rdata
);

   logic [7:0]  rbyte;
   logic [15:0] rhalf;

   // Select the addressed byte and halfword out of the stored word.
   always_comb begin
      rbyte = rword[7:0];
      case (lane)
         2'd0:    rbyte = rword[7:0];
         2'd1:    rbyte = rword[15:8];
         2'd2:    rbyte = rword[23:16];
         default: rbyte = rword[31:24];
      endcase
      rhalf = lane[1] ? rword[31:16] : rword[15:0];
   end

   // Store data is replicated across all lanes so the strobes alone pick
   // which bytes land; load data is extended from bit 7 or bit 15.
   always_comb begin
      wstrb = 4'b0000;
      wword = wdata;
      rdata = 32'd0;
      case (size)
         SIZE_BYTE: begin
            wstrb = 4'b0001 << lane;
            wword = {4{wdata[7:0]}};
            rdata = {{24{~is_unsigned & rbyte[7]}}, rbyte};
         end
         SIZE_HWORD: begin
            wstrb = lane[1] ? 4'b1100 : 4'b0011;
            wword = {2{wdata[15:0]}};
            rdata = {{16{~is_unsigned & rhalf[15]}}, rhalf};
         end
         SIZE_WORD: begin
            wstrb = 4'b1111;
            wword = wdata;
            rdata = rword;
         end
         default: begin
            wstrb = 4'b0000;
            wword = wdata;
            rdata = 32'd0;
         end
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Data-memory target for the RV32I memory stage. Accepts one load/store at a
// time over valid/ready, waits LATENCY cycles, performs the access on a
// little-endian byte-addressable array and returns a registered response.
// Optional build macro:
//   DMEM_ALIGN_CHECK_EN  defined: misaligned halfword/word accesses error out.
//                        undefined: misaligned accesses are force-aligned.
// Parameters:
//   ADDR_WIDTH  byte-address bits decoded (capacity 2^ADDR_WIDTH bytes)
//   LATENCY     wait cycles between acceptance and response (>= 1)
// Ports:
//   clk           in  1   clock, rising edge
//   rst           in  1   asynchronous active-low reset
//   req_valid     in  1   request present
//   req_ready     out 1   high only in IDLE
//   req_rw        in  1   1 = read, 0 = write
//   req_size      in  2   00 byte, 01 halfword, 10 word, 11 illegal
//   req_unsigned  in  1   loads: 1 zero-extend, 0 sign-extend
//   req_addr      in  32  byte address
//   req_wdata     in  32  right-aligned store data
//   rsp_valid     out 1   response present
//   rsp_ready     in  1   requester takes the response
//   rsp_rdata     out 32  extended load data, 0 for writes and errors
//   rsp_err       out 1   illegal access, nothing written
// Array contents are neither initialised nor cleared by reset.
// ---------------------------------------------------------------------------
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int LATENCY    = 2
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_rw,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int WORDS = 2 ** (ADDR_WIDTH - 2);
   localparam int IDX_W = (ADDR_WIDTH > 2) ? (ADDR_WIDTH - 2) : 1;
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic              lat_rw;
   logic [1:0]        lat_size;
   logic              lat_unsigned;
   logic [31:0]       lat_addr;
   logic [31:0]       lat_wdata;

   logic [31:0]       mem [WORDS];
   logic [IDX_W-1:0]  word_idx;
   logic [1:0]        lane;
   logic              misaligned;
   logic              access_err;
   logic              do_access;
   logic [31:0]       rword;
   logic [3:0]        wstrb;
   logic [31:0]       wword;
   logic [31:0]       lane_rdata;

   // With only one word in the array there are no index bits to decode.
   generate
      if (ADDR_WIDTH > 2) begin : g_idx
         assign word_idx = lat_addr[ADDR_WIDTH-1:2];
      end else begin : g_idx_single
         assign word_idx = '0;
      end
   endgenerate

   // Force-align the lane for halfword/word; when alignment checking is
   // enabled the misaligned case is flagged as an error instead, so the
   // forced lane never reaches the array.
   always_comb begin
      lane = lat_addr[1:0];
      case (lat_size)
         SIZE_HWORD: lane = {lat_addr[1], 1'b0};
         SIZE_WORD:  lane = 2'b00;
         default:    lane = lat_addr[1:0];
      endcase
   end

`ifdef DMEM_ALIGN_CHECK_EN
   assign misaligned = ((lat_size == SIZE_HWORD) && lat_addr[0]) ||
                       ((lat_size == SIZE_WORD)  && (lat_addr[1:0] != 2'b00));
`else
   assign misaligned = 1'b0;
`endif

   assign access_err = (lat_size == SIZE_ILLEGAL) ||
                       ((lat_addr >> ADDR_WIDTH) != 32'd0) ||
                       misaligned;

   assign do_access = (state == WAIT) && (cnt == '0);
   assign rword     = mem[word_idx];

   dmem_lane_ctrl u_lane_ctrl (
      .size        (lat_size),
      .lane        (lane),
      .is_unsigned (lat_unsigned),
      .wdata       (lat_wdata),
      .rword       (rword),
      .wstrb       (wstrb),
      .wword       (wword),
      .rdata       (lane_rdata)
   );

   // Array write port: only on the WAIT->RESP edge of a legal store. Reset
   // forces the FSM out of WAIT, so an interrupted store never lands.
   always_ff @(posedge clk) begin
      if (do_access && (lat_rw == MemRW_Write) && !access_err) begin
         for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) begin
               mem[word_idx][8*i +: 8] <= wword[8*i +: 8];
            end
         end
      end
   end

   // Request/response FSM. Request fields are captured only at acceptance,
   // and the response is registered on the same edge the access happens so
   // it stays stable for as long as the requester stalls in RESP.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         cnt          <= '0;
         req_ready    <= 1'b1;
         rsp_valid    <= 1'b0;
         rsp_rdata    <= 32'd0;
         rsp_err      <= 1'b0;
         lat_rw       <= MemRW_Read;
         lat_size     <= SIZE_BYTE;
         lat_unsigned <= 1'b0;
         lat_addr     <= 32'd0;
         lat_wdata    <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  lat_rw       <= req_rw;
                  lat_size     <= req_size;
                  lat_unsigned <= req_unsigned;
                  lat_addr     <= req_addr;
                  lat_wdata    <= req_wdata;
                  cnt          <= CNT_W'(LATENCY - 1);
                  req_ready    <= 1'b0;
                  state        <= WAIT;
               end
            end
            WAIT: begin
               if (cnt == '0) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= access_err;
                  rsp_rdata <= (access_err || (lat_rw == MemRW_Write)) ?
                               32'd0 : lane_rdata;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
                  rsp_rdata <= 32'd0;
                  rsp_err   <= 1'b0;
                  req_ready <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
// Scoreboard bench for dmem_responder: the stimulus thread pushes the
// hand-computed response of every accepted request into a queue, and a
// monitor pops and compares whenever the DUT presents a response.
// Honours DMEM_ALIGN_CHECK_EN for the misaligned-halfword expectations.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

   localparam int ADDR_WIDTH = 12;
   localparam int LATENCY    = 2;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_rw;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          acc_cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc      = 0;
   int   hs_cyc   = -100;
   int   n_checks = 0;
   int   n_pass   = 0;
   bit   prev_valid = 0;

`ifdef DMEM_ALIGN_CHECK_EN
   localparam logic        HW_ERR  = 1'b1;
   localparam logic [31:0] HW_WORD = 32'hDEADBEEF;
`else
   localparam logic        HW_ERR  = 1'b0;
   localparam logic [31:0] HW_WORD = 32'hDEAD1234;
`endif

   dmem_responder #(.ADDR_WIDTH(ADDR_WIDTH), .LATENCY(LATENCY)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_rw       (req_rw),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err)
   );

   // Free-running clock and edge counter used for latency checks.
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endfunction

   function automatic void timeout(input string name);
      n_checks++;
      $display("[TB] FAIL %s: bound expired", name);
   endfunction

   // Monitor: samples one time unit after the falling edge. Every cycle a
   // response is held it is compared against the queue head; the head is
   // popped when the handshake will complete on the next rising edge.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (!rst) begin
            prev_valid = 0;
         end else begin
            if (rsp_valid) begin
               if (sb.size() == 0) begin
                  check("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
               end else begin
                  if (!prev_valid)
                     check("latency", cyc - sb[0].acc_cyc, LATENCY);
                  check("rsp_rdata", rsp_rdata, sb[0].rdata);
                  check("rsp_err", {31'd0, rsp_err}, {31'd0, sb[0].err});
                  check("req_ready_busy", {31'd0, req_ready}, 32'd0);
                  if (rsp_ready) begin
                     void'(sb.pop_front());
                     hs_cyc = cyc + 1;
                  end
               end
            end
            prev_valid = rsp_valid;
         end
      end
   end

   // Present a request, wait (bounded) for acceptance, optionally register
   // its expected response, then drop req_valid after the accepting edge.
   task automatic apply_stimulus(input logic rw, input logic [1:0] size,
                                 input logic uns, input logic [31:0] addr,
                                 input logic [31:0] wdata,
                                 input logic [31:0] exp_rdata,
                                 input logic exp_err, input bit track);
      bit ok = 0;
      @(negedge clk);
      req_rw       = rw;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      req_valid    = 1'b1;
      for (int n = 0; n < 50; n++) begin
         #1;
         if (req_ready) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         timeout("accept_wait");
      end else if (track) begin
         sb.push_back('{exp_rdata, exp_err, cyc + 1});
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_done();
      bit ok = 0;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         #2;
         if (sb.size() == 0) begin
            ok = 1;
            break;
         end
      end
      if (!ok) timeout("rsp_wait");
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
      check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
      check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
      check({tag, "_rsp_err"},   {31'd0, rsp_err},   32'd0);
   endtask

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      bit ok;
      int acc;
      rst          = 1'b0;
      req_valid    = 1'b0;
      req_rw       = 1'b1;
      req_size     = 2'b00;
      req_unsigned = 1'b0;
      req_addr     = 32'd0;
      req_wdata    = 32'd0;
      rsp_ready    = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b1;

      // Word store/load, then byte lanes with sign/zero extension.
      apply_stimulus(1'b0, 2'b10, 1'b0, 32'h010, 32'hDEADBEEF, 32'h0, 1'b0, 1);
      wait_done();
      apply_stimulus(1'b1, 2'b10, 1'b0, 32'h010, 32'h0, 32'hDEADBEEF, 1'b0, 1);
      wait_done();
      apply_stimulus(1'b0, 2'b00, 1'b0, 32'h013, 32'hFFFFFF80, 32'h0, 1'b0, 1);
      wait_done();
      apply_stimulus(1'b1, 2'b00, 1'b0, 32'h013, 32'h0, 32'hFFFFFF80, 1'b0, 1);
      wait_done();
      apply_stimulus(1'b1, 2'b00, 1'b1, 32'h013, 32'h0, 32'h00000080, 1'b0, 1);
      wait_done();
      apply_stimulus(1'b1, 2'b10, 1'b0, 32'h010, 32'h0, 32'h80ADBEEF, 1'b0, 1);
      wait_done();
      apply_stimulus(1'b1, 2'b01, 1'b0, 32'h012, 32'h0, 32'hFFFF80AD, 1'b0, 1);
      wait_done();
      apply_stimulus(1'b1, 2'b01, 1'b1, 32'h010, 32'h0, 32'h0000BEEF, 1'b0, 1);
      wait_done();

      // Misaligned halfword store on a freshly restored word.
      apply_stimulus(1'b0, 2'b10, 1'b0, 32'h010, 32'hDEADBEEF, 32'h0, 1'b0, 1);
      wait_done();
      apply_stimulus(1'b0, 2'b01, 1'b0, 32'h011, 32'h00001234, 32'h0, HW_ERR, 1);
      wait_done();
      apply_stimulus(1'b1, 2'b10, 1'b0, 32'h010, 32'h0, HW_WORD, 1'b0, 1);
      wait_done();

      // Out-of-range and illegal-size accesses.
      apply_stimulus(1'b1, 2'b10, 1'b0, 32'h1000, 32'h0, 32'h0, 1'b1, 1);
      wait_done();
      apply_stimulus(1'b1, 2'b11, 1'b0, 32'h000, 32'h0, 32'h0, 1'b1, 1);
      wait_done();
      apply_stimulus(1'b0, 2'b11, 1'b0, 32'h010, 32'h0, 32'h0, 1'b1, 1);
      wait_done();
      apply_stimulus(1'b1, 2'b10, 1'b0, 32'h010, 32'h0, HW_WORD, 1'b0, 1);
      wait_done();

      // Stall the response for 5 cycles while a new request is pending.
      rsp_ready = 1'b0;
      apply_stimulus(1'b1, 2'b00, 1'b1, 32'h013, 32'h0, 32'h000000DE, 1'b0, 1);
      req_rw    = 1'b0;
      req_size  = 2'b10;
      req_addr  = 32'h030;
      req_wdata = 32'hCAFEF00D;
      req_valid = 1'b1;
      ok = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         #1;
         if (rsp_valid) begin
            ok = 1;
            break;
         end
      end
      if (!ok) timeout("stall_rsp_wait");
      repeat (5) @(negedge clk);
      rsp_ready = 1'b1;
      ok = 0;
      for (int n = 0; n < 20; n++) begin
         #1;
         if (req_ready) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         timeout("stall_accept_wait");
      end else begin
         acc = cyc + 1;
         check("accept_after_hs", acc, hs_cyc + 1);
         sb.push_back('{32'h0, 1'b0, acc});
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      wait_done();
      apply_stimulus(1'b1, 2'b10, 1'b0, 32'h030, 32'h0, 32'hCAFEF00D, 1'b0, 1);
      wait_done();

      // Reset during WAIT of a store: response dropped, store not performed.
      apply_stimulus(1'b0, 2'b10, 1'b0, 32'h020, 32'h11223344, 32'h0, 1'b0, 1);
      wait_done();
      apply_stimulus(1'b0, 2'b10, 1'b0, 32'h020, 32'h00000055, 32'h0, 1'b0, 0);
      rst = 1'b0;
      #1;
      check_reset_outputs("midwait_reset");
      repeat (2) @(negedge clk);
      rst = 1'b1;
      apply_stimulus(1'b1, 2'b10, 1'b0, 32'h020, 32'h0, 32'h11223344, 1'b0, 1);
      wait_done();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined RV32I core: the target side of the memory stage's load/store requests. Accepts one request at a time over a valid/ready handshake and services it after a fixed wait. Stores use byte, halfword or word granularity. Loads return sign- or zero-extended data. Returns an error flag for illegal accesses. Owns a little-endian byte-addressable array and replaces the core's ideal single-cycle memory model.

## Interface
- `ADDR_WIDTH`, default 12: byte-address bits decoded; capacity is 2^ADDR_WIDTH bytes, must be ≥ 2.
- `LATENCY`, default 2: wait cycles between acceptance and response, must be ≥ 1.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept; high only in IDLE.
- `req_rw`  in  1  1 = read, 0 = write (MemRW convention).
- `req_size`  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- `req_unsigned`  in  1  loads only: 1 zero-extends (LBU/LHU), 0 sign-extends.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned (bits [7:0] / [15:0] / [31:0] used).
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  requester takes the response.
- `rsp_rdata`  out  32  extended load data; 0 for writes and errors.
- `rsp_err`  out  1  access was illegal; no array state changed.

## Operation
- FSM states:
  - IDLE: `req_ready` = 1.
  - WAIT: counter runs.
  - RESP: `rsp_valid` = 1.
- IDLE → WAIT when `req_valid` & `req_ready`. On that edge, latch rw, size, unsigned, addr and wdata, and load the counter with LATENCY−1.
- WAIT: the counter decrements each cycle. When it reaches 0 the FSM moves to RESP, and on that same edge:
  - the access is performed;
  - `rsp_rdata` and `rsp_err` are registered.
- RESP → IDLE on `rsp_valid` & `rsp_ready`. Otherwise hold, with `rsp_rdata` and `rsp_err` stable.
- Error conditions (any one sets `rsp_err` = 1, suppresses the write, and forces `rsp_rdata` = 0):
  - `req_size` = 11;
  - `req_addr[31:ADDR_WIDTH]` ≠ 0;
  - misalignment (see Configuration).
- Byte lane = `addr[1:0]`; array word index = `addr[ADDR_WIDTH-1:2]`.
- Stores touch only the addressed lanes; the other bytes of the word are unchanged.
- Loads: extract the lane(s), then extend to 32 bits from bit 7 (byte) or bit 15 (halfword) using `req_unsigned`. `req_unsigned` is ignored for word loads and for writes.
- Writes also respond, with `rsp_rdata` = 0.
- Array contents are not initialised and not cleared by reset.

## Timing
- Reset values: state IDLE, `req_ready` = 1, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0, counter = 0.
- Latency: if accepted on edge T, `rsp_valid` rises after edge T+LATENCY. A store is visible to any later request.
- One request outstanding; `req_ready` = 0 throughout WAIT and RESP.
- A request presented in the same cycle as the response handshake is not accepted. The earliest next acceptance is the cycle after returning to IDLE.
- Peak throughput: one access per LATENCY+2 cycles with `rsp_ready` tied high.
- Request inputs are sampled only at acceptance; changes during WAIT/RESP are ignored.
- Reset asserted mid-WAIT or mid-RESP: the FSM returns to IDLE immediately and the response is dropped. A store that has not yet reached the RESP edge is not performed.

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined: a halfword with `addr[0]` = 1, or a word with `addr[1:0]` ≠ 00, sets `rsp_err` and performs no write.
- `DMEM_ALIGN_CHECK_EN` undefined: misaligned accesses are force-aligned. The halfword clears `addr[0]`; the word clears `addr[1:0]`. The access then proceeds with no error. Size-11 and out-of-range errors remain.

## Structure
- Shared package `dmem_pkg`:
  - size codes (SIZE_BYTE / SIZE_HWORD / SIZE_WORD);
  - MemRW_Read / MemRW_Write;
  - the FSM state enum (IDLE, WAIT, RESP).
- One combinational sub-module, `dmem_lane_ctrl`. From size and addr[1:0] it produces:
  - byte-write strobes and the lane-shifted write word;
  - extraction and extension of the load data.

## Test plan
- Reset, then word store 0xDEADBEEF to 0x010, then word load 0x010 with `rsp_ready` = 1 → `rsp_rdata` = 0xDEADBEEF, `rsp_err` = 0. `rsp_valid` is seen exactly LATENCY edges after each acceptance.
- Byte store 0x80 to 0x013, then signed byte load 0x013 → 0xFFFFFF80. Unsigned byte load 0x013 → 0x00000080. Word load 0x010 → 0x80ADBEEF.
- Halfword store 0x1234 to 0x011:
  - with the macro: `rsp_err` = 1 and word 0x010 is unchanged;
  - without the macro: the store hits 0x010 and word 0x010 reads 0xDEAD1234.
- `req_addr` = 2^ADDR_WIDTH with a word read → `rsp_err` = 1, `rsp_rdata` = 0. Same for `req_size` = 11 at 0x000.
- Hold `rsp_ready` = 0 for 5 cycles in RESP while driving new requests → `rsp_valid`, `rsp_rdata` and `rsp_err` stay stable and `req_ready` stays 0. The request is accepted only after the handshake plus one cycle.
- Assert `rst` low mid-WAIT of a store 0x55 to 0x020, then release → outputs return to reset values. A subsequent load of 0x020 does not return 0x00000055 (the word holds its pre-store contents).
